// File: rtl/bypass_cfg_pkg.sv
// Shared types and constants for the bypass-mux configuration controller.
// Optional parity checking is enabled by defining BYPASS_CFG_PARITY_EN.
package bypass_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic SEL_BYPASS = 1'b0;
  localparam logic SEL_GATE   = 1'b1;

  // Number of serial bits expected per load (payload plus optional parity).
  function automatic int exp_bits(input int n_mux);
`ifdef BYPASS_CFG_PARITY_EN
    return n_mux + 1;
`else
    return n_mux;
`endif
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// MSB-first shadow shift register with transfer counter; only the first
// WIDTH bits are shifted in, later bits (parity) only advance the count.
module cfg_shift_reg #(
  parameter int WIDTH = 2,
  parameter int TOTAL = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Next shadow value: shift left inserting din while still in the payload.
  always_comb begin
    w_next = r_data;
    if (r_count < CNT_W'(WIDTH)) begin
      w_next[0] = din;
      for (int i = 1; i < WIDTH; i++) begin
        w_next[i] = r_data[i-1];
      end
    end else begin
      w_next = r_data;
    end
  end

  // Shadow and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (en) begin
      r_data  <= w_next;
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_data  <= r_data;
      r_count <= r_count;
    end
  end

  assign data  = r_data;
  assign count = r_count;
  assign full  = (r_count == CNT_W'(TOTAL));

endmodule

// File: rtl/bypass_mux_cfg_ctrl.sv
// Serial config loader for a bank of 2:1 bypass muxes with atomic commit.
// Define BYPASS_CFG_PARITY_EN to require a trailing even-parity bit.
module bypass_mux_cfg_ctrl
  import bypass_cfg_pkg::*;
#(
  parameter  int N_MUX  = 2,
  localparam int N_BITS = exp_bits(N_MUX),
  localparam int CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic [N_MUX-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  logic             r_cfg_ready;
  logic [N_MUX-1:0] r_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [N_MUX-1:0] w_shadow;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_xfer;
  logic             w_clr;
  logic             w_last;
  logic             w_par_ok;

  assign w_xfer = cfg_valid & r_cfg_ready & ~w_full;
  assign w_clr  = (r_state == IDLE) & load_start;
  assign w_last = w_xfer & (w_count == CNT_W'(N_BITS - 1));

  cfg_shift_reg #(
    .WIDTH(N_MUX),
    .TOTAL(N_BITS),
    .CNT_W(CNT_W)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_xfer),
    .din  (cfg_bit),
    .data (w_shadow),
    .count(w_count),
    .full (w_full)
  );

`ifdef BYPASS_CFG_PARITY_EN
  logic r_par;

  // Capture the trailing parity bit; it never enters the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_xfer && (w_count == CNT_W'(N_MUX))) begin
      r_par <= cfg_bit;
    end else begin
      r_par <= r_par;
    end
  end

  assign w_par_ok = ((^w_shadow) == r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  // Load FSM with registered handshake, status and commit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b0;
      r_sel       <= {N_MUX{SEL_BYPASS}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state     <= SHIFT;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_state     <= COMMIT;
            r_cfg_ready <= 1'b0;
          end else begin
            r_state     <= SHIFT;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          // A parity mismatch rejects the load without touching sel.
          if (w_par_ok) begin
            r_sel  <= w_shadow;
            r_done <= 1'b1;
          end else begin
            r_err  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/bypass_mux_cfg_ctrl.md
Name: bypass_mux_cfg_ctrl

Overview:
Configuration controller for a bank of 2:1 bypass muxes. Each mux selects between a raw input (I0) and a gate output (I1).
- Accepts a serial configuration bitstream over a valid/ready handshake and assembles it in a shadow register.
- Commits the shadow register atomically to the mux select outputs.
- Sits between the fabric configuration port and the mux select inputs; the sel bits are the runtime equivalent of the FASM mux feature bits.

Parameters:
N_MUX, 2, number of muxes controlled (one select bit each); legal range 1..64.
CNT_W, $clog2(N_MUX+1), width of the bit counter; derived, not overridden.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
load_start  input  1  single-cycle request to begin a load
cfg_valid  input  1  cfg_bit is valid this cycle
cfg_bit  input  1  serial config bit, mux N_MUX-1 first (MSB first)
cfg_ready  output  1  controller accepts cfg_bit this cycle
sel  output  N_MUX  committed mux selects; 0 = I0 (bypass), 1 = I1 (gate path)
busy  output  1  load in progress (SHIFT or COMMIT)
done  output  1  single-cycle pulse when a commit is applied
err  output  1  single-cycle pulse on a rejected load (only with optional feature)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; sel=0 (all muxes bypass); shadow=0; count=0.
  - cfg_ready=0, busy=0, done=0, err=0.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - cfg_ready=0, busy=0.
  - load_start=1 -> SHIFT next cycle; count cleared to 0.
  - cfg_valid in IDLE is ignored.
- SHIFT:
  - cfg_ready=1, busy=1.
  - A transfer occurs when cfg_valid & cfg_ready. On each transfer: shadow <= {shadow[N_MUX-2:0], cfg_bit}, count <= count+1.
  - When the transfer brings count to N_MUX -> COMMIT next cycle.
  - cfg_valid=0 stalls indefinitely; there is no timeout.
  - load_start while busy is ignored (no restart).
- COMMIT:
  - Lasts 1 cycle; cfg_ready=0, busy=1.
  - sel <= shadow at the end of the cycle; done=1 in the cycle after COMMIT, coincident with the new sel value; state returns to IDLE.
- Latency: the last accepted bit at cycle t -> COMMIT at t+1 -> sel updated and done=1 at t+2.
- sel never changes except on a commit or reset. There are no partial updates.
- load_start arriving in the same cycle that done pulses (state already IDLE) is accepted normally.
- Reset mid-SHIFT discards the shadow; sel returns to 0.
- N_MUX=1: a single transfer leads to COMMIT.
- count never exceeds N_MUX. No transfers are accepted once count==N_MUX.

Optional Feature:
Macro: BYPASS_CFG_PARITY_EN.
- Defined:
  - SHIFT expects N_MUX+1 bits; the final bit is even parity over the payload (XOR of payload bits must equal the parity bit).
  - On match: normal COMMIT and done.
  - On mismatch: COMMIT is skipped, sel is unchanged, err=1 for one cycle at the same timing as done would have been, and state returns to IDLE.
  - The parity bit is not stored in shadow. CNT_W is sized for N_MUX+1.
- Undefined: no parity bit; the err port exists but is tied to 0.

Decomposition:
- Package bypass_cfg_pkg holds:
  - the state enum (IDLE, SHIFT, COMMIT);
  - the sel encoding constants SEL_BYPASS=0, SEL_GATE=1;
  - a helper function for the expected bit count (N_MUX, or N_MUX+1 with parity).
- One sub-module, cfg_shift_reg: parameterised shift register with enable and count/full flag.
- The FSM, commit register and handshake logic stay in the top module.

Test Plan:
1. Reset, N_MUX=2 -> sel=2'b00, cfg_ready=0, busy=0, done=0 immediately on rst assertion (before any clk edge).
2. load_start, then bits 1,0 with continuous cfg_valid -> sel=2'b10 and done=1 exactly 2 cycles after the second transfer; busy drops the same cycle.
3. Same load with cfg_valid deasserted for 5 cycles between the bits -> cfg_ready held at 1, no count advance, final sel=2'b10.
4. load_start pulsed again mid-SHIFT, plus 3 bits presented (1,1,1) -> second start ignored; only 2 accepted; sel=2'b11; the third bit sees cfg_ready=0.
5. Load 1 bit, then assert rst mid-SHIFT -> sel=2'b00 from a prior 2'b11, state IDLE; a following full load of 0,1 yields sel=2'b01.
6. With BYPASS_CFG_PARITY_EN: bits 1,1,parity 0 -> sel=2'b11, done. Then bits 1,0,parity 0 -> err=1, done=0, sel stays 2'b11.
